// File: rtl/life_ctrl.sv
// Upstream controller for the life_col4 tile array: bit-serial pattern load
// followed by paced generation-advance pulses.
module life_ctrl #(
  parameter int COLS  = 4,
  parameter int COL_W = 2,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             write_enb,
  output logic             val,
  output logic [1:0]       row,
  output logic [COL_W-1:0] col,
  output logic             enable,
  output logic             busy,
  output logic [15:0]      gen_count
);

  localparam int CUR_W = COL_W + 2;
  localparam logic [CUR_W-1:0] LAST = CUR_W'(4 * COLS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state, state_nx;
  logic [CUR_W-1:0] cursor, cursor_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic             we_nx, val_nx, en_nx;
  logic [1:0]       row_nx;
  logic [COL_W-1:0] col_nx;
  logic [15:0]      gen_nx;
  logic             accept;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx  = state;
    cursor_nx = cursor;
    div_nx    = div_cnt;
    we_nx     = 1'b0;
    val_nx    = val;
    row_nx    = row;
    col_nx    = col;
    en_nx     = 1'b0;
    gen_nx    = gen_count;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nx  = LOAD;
          cursor_nx = '0;
        end else if (run) begin
          state_nx = RUN;
          div_nx   = '0;
        end
      end
      LOAD: begin
        // A bit accepted alongside load_start still lands at its old address.
        if (accept) begin
          we_nx     = 1'b1;
          val_nx    = in_bit;
          row_nx    = cursor[1:0];
          col_nx    = cursor[CUR_W-1:2];
          cursor_nx = cursor + CUR_W'(1);
        end
        if (load_start) begin
          cursor_nx = '0;
        end else if (accept && cursor == LAST) begin
          state_nx  = run ? RUN : IDLE;
          cursor_nx = '0;
          div_nx    = '0;
          gen_nx    = '0;
        end
      end
      RUN: begin
        if (load_start) begin
          state_nx  = LOAD;
          cursor_nx = '0;
        end else if (!run) begin
          state_nx = IDLE;
        end else if (div_cnt >= period) begin
          en_nx  = 1'b1;
          div_nx = '0;
          gen_nx = gen_count + 16'd1;
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cursor    <= '0;
      div_cnt   <= '0;
      write_enb <= 1'b0;
      val       <= 1'b0;
      row       <= '0;
      col       <= '0;
      enable    <= 1'b0;
      gen_count <= '0;
    end else begin
      state     <= state_nx;
      cursor    <= cursor_nx;
      div_cnt   <= div_nx;
      write_enb <= we_nx;
      val       <= val_nx;
      row       <= row_nx;
      col       <= col_nx;
      enable    <= en_nx;
      gen_count <= gen_nx;
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Directed/randomized bench for life_ctrl: pattern load addressing, pulse
// pacing from a cycle-level reference model, load preemption and wrap.
module tb_life_ctrl;
  localparam int COLS  = 4;
  localparam int COL_W = 2;
  localparam int DIV_W = 16;
  localparam int CELLS = 4 * COLS;

  logic             clk;
  logic             reset;
  logic             load_start;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             run;
  logic [DIV_W-1:0] period;
  logic             write_enb;
  logic             val;
  logic [1:0]       row;
  logic [COL_W-1:0] col;
  logic             enable;
  logic             busy;
  logic [15:0]      gen_count;

  life_ctrl #(.COLS(COLS), .COL_W(COL_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_bit(in_bit), .run(run), .period(period),
    .write_enb(write_enb), .val(val), .row(row), .col(col),
    .enable(enable), .busy(busy), .gen_count(gen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_gen  = 0;
  int mcnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(write_enb), 0);
    check({tag, "_val"},   32'(val), 0);
    check({tag, "_row"},   32'(row), 0);
    check({tag, "_col"},   32'(col), 0);
    check({tag, "_en"},    32'(enable), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_rdy"},   32'(in_ready), 0);
    check({tag, "_gen"},   32'(gen_count), 0);
  endtask

  // Feeds CELLS bits; expects each accept to appear as a write one cycle later
  // at cell index = col*4+row. restart_at re-asserts load_start with that accept.
  task automatic do_load(input logic [15:0] pat, input bit gappy, input int restart_at,
                         input bit pulse_start);
    int  idx = 0;
    int  cyc = 0;
    int  last_addr = -1;
    bit  restarted = 0;
    bit  acc, rs;
    int  addr;
    if (pulse_start) begin
      load_start = 1'b1;
      in_valid   = 1'b0;
      step();
      load_start = 1'b0;
      check("load_busy", 32'(busy), 1);
    end
    while (idx < CELLS && cyc < 200) begin
      in_valid = gappy ? (cyc % 2 == 1) : 1'b1;
      in_bit   = pat[idx];
      rs = in_valid && !restarted && (idx == restart_at);
      load_start = rs;
      check("in_ready_load", 32'(in_ready), 1);
      acc  = in_valid;
      addr = idx;
      step();
      load_start = 1'b0;
      cyc++;
      check("en_in_load", 32'(enable), 0);
      if (acc) begin
        check("we_acc",  32'(write_enb), 1);
        check("row_acc", 32'(row), addr % 4);
        check("col_acc", 32'(col), addr / 4);
        check("val_acc", 32'(val), 32'(pat[addr]));
        last_addr = addr;
        if (rs) begin
          idx = 0;
          restarted = 1;
        end else begin
          idx++;
        end
      end else begin
        check("we_gap", 32'(write_enb), 0);
        if (last_addr >= 0) begin
          check("row_hold", 32'(row), last_addr % 4);
          check("col_hold", 32'(col), last_addr / 4);
        end
      end
    end
    in_valid = 1'b0;
    if (idx < CELLS) check("load_timeout", idx, CELLS);
    check("last_cell", last_addr, CELLS - 1);
    check("rdy_after_load",  32'(in_ready), 0);
    check("busy_after_load", 32'(busy), 0);
    check("gen_clear", 32'(gen_count), 0);
    exp_gen = 0;
  endtask

  task automatic enter_run();
    run = 1'b1;
    step();
    mcnt = 0;
    check("enter_run_en", 32'(enable), 0);
    check("enter_run_busy", 32'(busy), 0);
  endtask

  // Reference: counter counts cycles since entry/last pulse; pulse when it
  // has reached the live period value at a compare.
  task automatic run_cycles(input int n);
    bit fire;
    for (int i = 0; i < n; i++) begin
      fire = (mcnt >= int'(period));
      step();
      if (fire) begin
        exp_gen = (exp_gen + 1) & 16'hFFFF;
        mcnt = 0;
      end else begin
        mcnt++;
      end
      check("run_en",  32'(enable), 32'(fire));
      check("run_gen", 32'(gen_count), exp_gen);
      check("run_we",  32'(write_enb), 0);
    end
  endtask

  task automatic stop_run();
    run = 1'b0;
    step();
    check("stop_en", 32'(enable), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_en",  32'(enable), 0);
      check("idle_gen", 32'(gen_count), exp_gen);
      check("idle_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    reset = 1'b0; load_start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    run = 1'b0; period = '0;
    step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    step();
    check_all_zero("rst");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_all_zero("post_rst");
    end
    in_valid = 1'b0;

    do_load(16'h5555, 1'b0, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_we", 32'(write_enb), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_en", 32'(enable), 0);
    end

    do_load(16'($urandom), 1'b1, -1, 1'b1);

    period = DIV_W'(3);
    enter_run();
    run_cycles(40);
    check("gen_after_10", 32'(gen_count), 10);
    stop_run();

    for (int k = 0; k < 3; k++) begin
      period = DIV_W'($urandom_range(0, 5));
      enter_run();
      run_cycles($urandom_range(10, 30));
      stop_run();
    end

    period = DIV_W'(10);
    enter_run();
    run_cycles(6);
    period = DIV_W'(2);
    run_cycles(1);
    check("lower_period_fire", 32'(enable), 1);
    run_cycles(7);
    stop_run();

    period = '0;
    enter_run();
    run_cycles(5);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("preempt_en",   32'(enable), 0);
    check("preempt_rdy",  32'(in_ready), 1);
    check("preempt_busy", 32'(busy), 1);
    check("preempt_we",   32'(write_enb), 0);
    run = 1'b0;
    do_load(16'($urandom), 1'b0, 5, 1'b0);

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midload_rst");
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    check("after_rst_busy", 32'(busy), 0);
    check("after_rst_we", 32'(write_enb), 0);

    period = '0;
    exp_gen = 0;
    enter_run();
    for (int i = 0; i < 65535; i++) step();
    check("gen_ffff", 32'(gen_count), 32'hFFFF);
    step();
    check("gen_wrap", 32'(gen_count), 0);
    check("wrap_en",  32'(enable), 1);
    check("wrap_busy", 32'(busy), 0);
    check("wrap_we",  32'(write_enb), 0);
    check("wrap_rdy", 32'(in_ready), 0);
    run = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/life_ctrl.md
Name: life_ctrl

Overview:
- Upstream controller for the life_col4 tile array: loads an initial pattern bit-serially into the grid, then paces generation steps.
- Drives the shared write_enb/val/row lines and a column index. An external decoder gates write_enb to the addressed column.
- Drives the global enable that advances every cell by one generation.
- Sits between the host/pattern source (valid/ready bit stream) and the column array.

Parameters:
- COLS, 4, number of 4-row columns in the grid; cells = 4*COLS.
- COL_W, 2, width of the col output; must satisfy 2**COL_W >= COLS.
- DIV_W, 16, width of the generation-period counter and the period input.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle request to begin loading a pattern.
- in_valid  input  1  pattern bit valid.
- in_ready  output  1  controller accepts in_bit this cycle.
- in_bit  input  1  cell value; 1 = alive.
- run  input  1  level; high permits generation stepping.
- period  input  DIV_W  idle cycles between generation pulses.
- write_enb  output  1  registered write strobe to the addressed cell.
- val  output  1  registered value to write.
- row  output  2  registered row index within the column.
- col  output  COL_W  registered column index.
- enable  output  1  registered one-cycle generation-advance pulse.
- busy  output  1  high in LOAD.
- gen_count  output  16  generations issued since the last completed load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; cursor=0; div counter=0.
- Reset values of outputs: in_ready=0, write_enb=0, val=0, row=0, col=0, enable=0, busy=0, gen_count=0.
- Reset mid-load discards the partial load; cells already written are not restored.
- States: IDLE, LOAD, RUN.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - load_start -> LOAD, cursor=0.
  - Else if run=1 -> RUN, div counter=0.
- LOAD:
  - in_ready=1 and busy=1 throughout.
  - Handshake: a bit is accepted on cycles with in_valid&&in_ready.
  - On acceptance, the next cycle shows write_enb=1, val=in_bit, row=cursor[1:0], col=cursor/4. Latency is 1 cycle; write_enb is high for exactly one cycle per accepted bit.
  - Fill order: row 0..3 within col 0, then col 1, and so on. Cursor increments by 1 per accepted bit.
  - Back-to-back acceptance every cycle is allowed; throughput is 1 bit/cycle.
  - Acceptance of the last cell (cursor=4*COLS-1):
    - Next state is RUN if run=1, else IDLE.
    - in_ready drops in the following cycle.
    - gen_count clears to 0.
    - The final write strobe still appears 1 cycle after acceptance.
  - load_start during LOAD restarts the load with cursor=0. A bit accepted in the same cycle is written to its old address; the next accepted bit goes to cell 0.
  - enable is held 0 in LOAD.
- RUN:
  - The div counter increments each cycle.
  - When counter >= period (compared live): next cycle enable=1 for one cycle, counter resets to 0, gen_count increments.
  - period=0 gives enable every cycle.
  - Lowering period mid-run below the current count fires on the next compare.
  - run=0 -> IDLE. An enable pulse already registered still completes; no further pulses are issued.
  - load_start -> LOAD immediately, with cursor=0. It takes priority over the period compare in the same cycle, so no pulse is issued.
- write_enb and enable are never high in the same cycle.
- gen_count wraps 16'hFFFF -> 0.
- row/col/val hold their last values when write_enb=0.

Test Plan:
- Reset held low, with in_valid=1 and load_start pulsed: all outputs 0, in_ready=0. After release, outputs remain 0 until load_start.
- COLS=4, load_start then 16 consecutive valid bits 1,0,1,0,... with run=0:
  - write_enb high for 16 consecutive cycles, starting 1 cycle after the first accept.
  - (col,row) sequence (0,0),(0,1),(0,2),(0,3),(1,0)...(3,3); val alternates 1/0.
  - Returns to IDLE; busy low after the last accept.
- Load with in_valid toggling every other cycle: one write_enb pulse per accept, no gaps mis-addressed, cell 15 last.
- period=3, run=1 after load: enable pulses every 4 cycles. After 10 pulses gen_count=10. Dropping run stops pulses; state=IDLE.
- In RUN at period=0, assert load_start: the enable train stops immediately, in_ready=1 next cycle, and the first accepted bit writes col=0,row=0.
- Force gen_count to 16'hFFFF via 65535 pulses at period=0: one more pulse gives gen_count=0, with no other state change.
